udp_rx_frame_checker: RTL and testbench

Receive-side traffic checker that sits directly downstream of the 10G UDP stack's user receive port (`m_axis_user_*`) and consumes every frame the stack delivers. It verifies each UDP payload against the incrementing-byte pattern the team's AXIS traffic source transmits. It also checks frame length against the `tuser` length field, `tkeep` legality and frame-to-frame sequence continuity, and exposes saturating frame, byte and error counters for loopback bring-up.

---
 rtl/udp_rx_frame_checker_if.sv | 17 +
 rtl/udp_rx_frame_checker.sv | 185 ++++++++++++++++++
 tb/tb_udp_rx_frame_checker.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_frame_checker_if.sv
// AXI-Stream receive bundle from the UDP stack's user port.
// master drives beats, slave (the checker) only observes them.
interface udp_rx_frame_checker_if;
  logic [63:0] tdata;
  logic [31:0] tuser;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;

  modport master (
    output tdata, tuser, tkeep, tlast, tvalid
  );

  modport slave (
    input tdata, tuser, tkeep, tlast, tvalid
  );
endinterface

// File: rtl/udp_rx_frame_checker.sv
// Receive-side frame checker: incrementing-byte payload, length, tkeep, sequence.
// Ports: i_clk, i_rst_n, s_axis (slave), i_clear; frame pulse/err, counters, status.
module udp_rx_frame_checker #(
  parameter bit P_SEQ_CHECK = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  udp_rx_frame_checker_if.slave        s_axis,
  input  logic                         i_clear,
  output logic                         o_frame_done,
  output logic                         o_frame_err,
  output logic [31:0]                  o_frame_cnt,
  output logic [31:0]                  o_err_cnt,
  output logic [47:0]                  o_byte_cnt,
  output logic [3:0]                   o_err_status
);

  typedef enum logic {
    IDLE,
    BODY
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  prev_q, prev_d;
  logic        pv_valid_q, pv_valid_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [47:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]  status_q, status_d;

  logic        first;
  logic [7:0]  seed;
  logic [7:0]  exp_base;
  logic [7:0]  lane_exp;
  logic        data_miss;
  logic [3:0]  pop;
  logic        keep_ok_last;
  logic        keep_bad;
  logic [15:0] cnt_sum;
  logic [15:0] len_cur;
  logic        len_bad;
  logic        seq_bad;
  logic [3:0]  flags_acc;
  logic [48:0] byte_sum;

  logic        unused_tuser;
  assign unused_tuser = ^s_axis.tuser[31:16];

  // Per-beat checks
  always_comb begin
    first    = s_axis.tvalid && (state_q == IDLE);
    seed     = s_axis.tdata[63:56];
    // exp_base is the expected value of lane 7 on this beat
    exp_base = first ? seed : exp_q;
    lane_exp  = 8'd0;
    data_miss = 1'b0;
    pop       = 4'd0;
    for (int i = 0; i < 8; i++) begin
      lane_exp = exp_base + 8'(7 - i);
      if (s_axis.tkeep[i] &&
          (s_axis.tdata[8*i +: 8] != lane_exp))
        data_miss = 1'b1;
      pop = pop + 4'(s_axis.tkeep[i]);
    end

    case (s_axis.tkeep)
      8'h80, 8'hC0, 8'hE0, 8'hF0,
      8'hF8, 8'hFC, 8'hFE, 8'hFF:
        keep_ok_last = 1'b1;
      default:
        keep_ok_last = 1'b0;
    endcase
    keep_bad = s_axis.tlast ? !keep_ok_last
                            : (s_axis.tkeep != 8'hFF);

    cnt_sum = (first ? 16'd0 : cnt_q) + 16'(pop);
    len_cur = first ? s_axis.tuser[15:0] : len_q;
    len_bad = s_axis.tlast && (cnt_sum != len_cur);

    seq_bad = P_SEQ_CHECK && first && pv_valid_q &&
              (seed != prev_q + 8'd1);

    flags_acc = (first ? 4'd0 : flags_q) |
                {seq_bad, keep_bad, len_bad, data_miss};

    byte_sum = {1'b0, byte_cnt_q} + 49'(pop);
  end

  // Next state, commit and counters
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    prev_d      = prev_q;
    pv_valid_d  = pv_valid_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    status_d    = status_q;

    if (s_axis.tvalid) begin
      exp_d      = exp_base + 8'd8;
      len_d      = len_cur;
      cnt_d      = cnt_sum;
      flags_d    = flags_acc;
      byte_cnt_d = byte_sum[48] ? '1 : byte_sum[47:0];
      if (first) begin
        prev_d     = seed;
        pv_valid_d = 1'b1;
      end
      if (s_axis.tlast) begin
        state_d  = IDLE;
        done_d   = 1'b1;
        ferr_d   = |flags_acc;
        flags_d  = 4'd0;
        status_d = status_q | flags_acc;
        if (frame_cnt_q != '1)
          frame_cnt_d = frame_cnt_q + 32'd1;
        if ((|flags_acc) && (err_cnt_q != '1))
          err_cnt_d = err_cnt_q + 32'd1;
      end else begin
        state_d = BODY;
      end
    end

    // Clear beats any same-cycle update; the frame itself still commits
    if (i_clear) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      byte_cnt_d  = '0;
      status_d    = '0;
      pv_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      flags_q     <= '0;
      prev_q      <= '0;
      pv_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      prev_q      <= prev_d;
      pv_valid_q  <= pv_valid_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      status_q    <= status_d;
    end
  end

  assign o_frame_done = done_q;
  assign o_frame_err  = ferr_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_byte_cnt   = byte_cnt_q;
  assign o_err_status = status_q;

endmodule

// File: tb/tb_udp_rx_frame_checker.sv
// Self-checking bench for udp_rx_frame_checker.
// Random and directed frames against a byte-stream reference model.
module tb_udp_rx_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        frame_done;
  logic        frame_err;
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;
  logic [47:0] byte_cnt;
  logic [3:0]  err_status;

  udp_rx_frame_checker_if bus ();

  udp_rx_frame_checker #(.P_SEQ_CHECK(1'b1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .s_axis       (bus.slave),
    .i_clear      (clear),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_frame_cnt  (frame_cnt),
    .o_err_cnt    (err_cnt),
    .o_byte_cnt   (byte_cnt),
    .o_err_status (err_status)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Frame under construction
  logic [63:0] fd[$];
  logic [7:0]  fk[$];

  // Reference model state
  longint      m_frames, m_errs, m_bytes;
  logic [3:0]  m_status;
  logic [7:0]  m_prev;
  bit          m_pv;

  // Observed at the commit cycle of the last frame sent
  logic        obs_done, obs_err;
  logic [3:0]  exp_flags;

  function automatic void model_zero();
    m_frames = 0; m_errs = 0; m_bytes = 0;
    m_status = 4'd0; m_pv = 1'b0; m_prev = 8'd0;
  endfunction

  // Payload byte at position n is seed+n; disabled lanes carry junk
  task automatic build(input int len, input logic [7:0] seed,
                       input int bad_pos, input logic [7:0] bad_val);
    int beats;
    fd.delete(); fk.delete();
    beats = (len + 7) / 8;
    for (int k = 0; k < beats; k++) begin
      logic [63:0] w;
      logic [7:0]  kp;
      w = {$urandom, $urandom};
      kp = 8'd0;
      for (int j = 0; j < 8; j++) begin
        int n;
        n = 8 * k + j;
        if (n < len) begin
          kp[7-j] = 1'b1;
          w[63-8*j -: 8] = (n == bad_pos) ? bad_val : 8'(seed + n);
        end
      end
      fd.push_back(w);
      fk.push_back(kp);
    end
  endtask

  function automatic logic [3:0] ref_flags(input logic [15:0] tuser);
    logic [3:0]  f;
    logic [7:0]  sd;
    int          cnt;
    f = 4'd0;
    sd = fd[0][63:56];
    cnt = 0;
    for (int k = 0; k < fd.size(); k++) begin
      for (int j = 0; j < 8; j++)
        if (fk[k][7-j] && (fd[k][63-8*j -: 8] != 8'(sd + 8*k + j)))
          f[0] = 1'b1;
      cnt += $countones(fk[k]);
      if (k == fd.size() - 1) begin
        if (!(fk[k] inside {8'h80, 8'hC0, 8'hE0, 8'hF0,
                            8'hF8, 8'hFC, 8'hFE, 8'hFF}))
          f[2] = 1'b1;
      end else if (fk[k] != 8'hFF) begin
        f[2] = 1'b1;
      end
    end
    if (16'(cnt) != tuser) f[1] = 1'b1;
    if (m_pv && (sd != 8'(m_prev + 1))) f[3] = 1'b1;
    return f;
  endfunction

  // Drives the built frame; clr_last raises i_clear with the tlast beat
  task automatic send_frame(input logic [15:0] tuser, input bit clr_last);
    longint nb;
    exp_flags = ref_flags(tuser);
    nb = 0;
    for (int k = 0; k < fd.size(); k++) begin
      bus.tvalid = 1'b1;
      bus.tdata  = fd[k];
      bus.tkeep  = fk[k];
      bus.tlast  = (k == fd.size() - 1);
      bus.tuser  = (k == 0) ? {16'($urandom), tuser} : $urandom;
      clear      = clr_last && (k == fd.size() - 1);
      nb += $countones(fk[k]);
      @(posedge clk); #1;
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    clear      = 1'b0;
    obs_done = frame_done;
    obs_err  = frame_err;
    m_prev = fd[0][63:56];
    m_pv = 1'b1;
    m_frames++;
    m_bytes += nb;
    if (|exp_flags) m_errs++;
    m_status |= exp_flags;
    if (clr_last) model_zero();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
  endtask

  task automatic check_commit(input string nm);
    n_chk++;
    if (obs_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: got %b want 1", nm, obs_done);
    end
    n_chk++;
    if (obs_err !== (|exp_flags)) begin
      n_fail++;
      $display("FAIL %s frame_err: got %b want %b", nm, obs_err, |exp_flags);
    end
    n_chk++;
    if (frame_cnt !== 32'(m_frames)) begin
      n_fail++;
      $display("FAIL %s frame_cnt: got %0d want %0d", nm, frame_cnt, m_frames);
    end
    n_chk++;
    if (err_cnt !== 32'(m_errs)) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d want %0d", nm, err_cnt, m_errs);
    end
    n_chk++;
    if (byte_cnt !== 48'(m_bytes)) begin
      n_fail++;
      $display("FAIL %s byte_cnt: got %0d want %0d", nm, byte_cnt, m_bytes);
    end
    n_chk++;
    if (err_status !== m_status) begin
      n_fail++;
      $display("FAIL %s status: got %b want %b", nm, err_status, m_status);
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_chk++;
    if ({frame_done, frame_err, frame_cnt, err_cnt, byte_cnt, err_status}
        !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got %b %b %0d %0d %0d %b want all 0",
               nm, frame_done, frame_err, frame_cnt, err_cnt,
               byte_cnt, err_status);
    end
  endtask

  task automatic test_reset();
    model_zero();
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_release");
  endtask

  task automatic test_clean_1500();
    do_clear();
    build(1500, 8'h00, -1, 8'h00);
    send_frame(16'd1500, 1'b0);
    check_commit("clean1500");
    n_chk++;
    if ({frame_err, frame_cnt, byte_cnt, err_status} !==
        {1'b0, 32'd1, 48'd1500, 4'd0}) begin
      n_fail++;
      $display("FAIL clean1500_const: got err=%b cnt=%0d bytes=%0d st=%b want 0 1 1500 0",
               frame_err, frame_cnt, byte_cnt, err_status);
    end
    n_chk++;
    if (fk[fk.size()-1] !== 8'hF0 || fk.size() != 188) begin
      n_fail++;
      $display("FAIL clean1500_shape: got keep=%h beats=%0d want F0 188",
               fk[fk.size()-1], fk.size());
    end
    @(posedge clk); #1;
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %b want 0", frame_done);
    end
  endtask

  task automatic test_corrupt();
    do_clear();
    build(1500, 8'h00, 100, 8'h00);
    send_frame(16'd1500, 1'b0);
    check_commit("corrupt");
    n_chk++;
    if ({frame_err, err_cnt, err_status} !== {1'b1, 32'd1, 4'b0001}) begin
      n_fail++;
      $display("FAIL corrupt_const: got err=%b ecnt=%0d st=%b want 1 1 0001",
               frame_err, err_cnt, err_status);
    end
  endtask

  task automatic test_length_keep();
    do_clear();
    build(64, 8'h10, -1, 8'h00);
    send_frame(16'd60, 1'b0);
    check_commit("len");
    n_chk++;
    if (err_status !== 4'b0010) begin
      n_fail++;
      $display("FAIL len_status: got %b want 0010", err_status);
    end
    do_clear();
    build(24, 8'h20, -1, 8'h00);
    fk[1] = 8'h7F;
    send_frame(16'd23, 1'b0);
    check_commit("keep");
    n_chk++;
    if (err_status !== 4'b0100) begin
      n_fail++;
      $display("FAIL keep_status: got %b want 0100", err_status);
    end
    do_clear();
    build(16, 8'h30, -1, 8'h00);
    fk[1] = 8'h3F;
    send_frame(16'd14, 1'b0);
    check_commit("keep_last");
  endtask

  task automatic test_back_to_back();
    logic [7:0] sds[3];
    logic       dn[3];
    sds[0] = 8'd5; sds[1] = 8'd6; sds[2] = 8'd8;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      build(8, sds[i], -1, 8'h00);
      send_frame(16'd8, 1'b0);
      dn[i] = obs_done;
      check_commit($sformatf("b2b%0d", i));
      if (i == 1) begin
        n_chk++;
        if (err_status[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_seq_early: got %b want 0", err_status[3]);
        end
      end
    end
    n_chk++;
    if ({dn[0], dn[1], dn[2], err_status[3], frame_cnt, err_cnt} !==
        {4'b1111, 32'd3, 32'd1}) begin
      n_fail++;
      $display("FAIL b2b_const: got dn=%b%b%b seq=%b cnt=%0d ecnt=%0d want 111 1 3 1",
               dn[0], dn[1], dn[2], err_status[3], frame_cnt, err_cnt);
    end
  endtask

  task automatic test_clear_commit();
    do_clear();
    build(40, 8'h01, -1, 8'h00);
    send_frame(16'd40, 1'b0);
    build(8, 8'h07, 3, 8'hEE);
    send_frame(16'd8, 1'b0);
    check_commit("preload");
    build(16, 8'h08, -1, 8'h00);
    send_frame(16'd16, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
    check_all_zero("clear_commit");
    build(16, 8'h40, -1, 8'h00);
    send_frame(16'd16, 1'b0);
    check_commit("post_clear");
    n_chk++;
    if (err_status[3] !== 1'b0 || frame_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL post_clear_seq: got seq=%b cnt=%0d want 0 1",
               err_status[3], frame_cnt);
    end
    build(24, 8'h41, 2, 8'h00);
    send_frame(16'd24, 1'b1);
    n_chk++;
    if ({obs_done, obs_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL clear_on_last_pulse: got %b%b want 11", obs_done, obs_err);
    end
    check_commit("clear_on_last");
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      int          len;
      logic [7:0]  sd;
      int          bad;
      logic [15:0] tu;
      len = $urandom_range(1, 100);
      sd  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(m_prev + 1);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) - 1 : -1;
      build(len, sd, bad, 8'(sd + bad + 1 + $urandom_range(0, 200)));
      if ($urandom_range(0, 7) == 0)
        fk[fk.size()-1] = 8'($urandom);
      tu = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 120))
                                       : 16'(len);
      send_frame(tu, 1'b0);
      check_commit($sformatf("rnd%0d", f));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    build(40, 8'h90, -1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      bus.tvalid = 1'b1;
      bus.tdata  = fd[k];
      bus.tkeep  = fk[k];
      bus.tlast  = 1'b0;
      bus.tuser  = 32'd40;
      @(posedge clk); #1;
    end
    bus.tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk); #1;
    check_all_zero("reset_mid_hold");
    rst_n = 1'b1;
    model_zero();
    @(posedge clk); #1;
    build(16, 8'h33, -1, 8'h00);
    send_frame(16'd16, 1'b0);
    check_commit("after_reset");
    n_chk++;
    if ({frame_cnt, byte_cnt, err_cnt} !== {32'd1, 48'd16, 32'd0}) begin
      n_fail++;
      $display("FAIL after_reset_const: got %0d %0d %0d want 1 16 0",
               frame_cnt, byte_cnt, err_cnt);
    end
  endtask

  initial begin
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    bus.tdata  = '0;
    bus.tkeep  = '0;
    bus.tuser  = '0;
    test_reset();
    test_clean_1500();
    test_corrupt();
    test_length_keep();
    test_back_to_back();
    test_clear_commit();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
